// File: rtl/fb_pixel_arbiter.sv
// ============================================================================
// Module   : fb_pixel_arbiter
// Purpose  : Shares the single-port monochrome framebuffer RAM between VGA
//            byte fetches (absolute priority) and read-modify-write pixel
//            set/clear/invert commands. The optional full-screen clear engine
//            is enabled by defining FB_CLEAR_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_pixel_arbiter #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 12
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              VgaReq_i,
    input  logic [ADDR_W-1:0] VgaAddress_i,
    output logic [7:0]        VgaData_o,
    input  logic              PixValid_i,
    output logic              PixReady_o,
    input  logic [7:0]        PixX_i,
    input  logic [6:0]        PixY_i,
    input  logic [1:0]        PixOp_i,
    output logic              PixDone_o,
    output logic              PixError_o,
    input  logic              ClearStart_i,
    output logic              Busy_o,
    output logic [ADDR_W-1:0] RamAddress_o,
    output logic              RamWrite_o,
    output logic [7:0]        RamWData_o,
    input  logic [7:0]        RamRData_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_MODIFY = 3'd2,
        S_WRITE  = 3'd3
`ifdef FB_CLEAR_EN
        ,S_CLEAR = 3'd4
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_bit;
    logic [1:0]          r_op;
    logic [7:0]          r_byte;
    logic                r_done;
    logic                r_err;
    logic                r_vga_pend;

    logic                w_hs;
    logic                w_x_oor;
    logic                w_y_oor;
    logic                w_noop;
    logic [ADDR_W-1:0]   w_pix_addr;
    logic [7:0]          w_mask;
    logic [7:0]          w_mod_byte;
    logic                w_latch;
    logic                w_capture;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_fsm_we;
    logic [ADDR_W-1:0]   w_fsm_addr;
    logic [7:0]          w_wdata;

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(WIDTH * HEIGHT / 8 - 1);
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                w_clr_start;
    logic                w_clr_inc;
`else
    logic                w_unused_clear;
    assign w_unused_clear = ClearStart_i;
`endif

    assign w_x_oor    = {1'b0, PixX_i} >= 9'(WIDTH);
    assign w_y_oor    = {1'b0, PixY_i} >= 8'(HEIGHT);
    assign w_noop     = (PixOp_i == 2'b11);
    assign w_pix_addr = ADDR_W'(PixY_i[6:3]) * ADDR_W'(WIDTH) + ADDR_W'(PixX_i);

`ifdef FB_CLEAR_EN
    // A pending clear request blocks pixel handshakes so it wins the IDLE cycle.
    assign PixReady_o = (r_state == S_IDLE) && !ClearStart_i;
`else
    assign PixReady_o = (r_state == S_IDLE);
`endif
    assign w_hs   = PixValid_i && PixReady_o;
    assign Busy_o = (r_state != S_IDLE);

    assign w_mask = 8'b1 << r_bit;
    always_comb begin
        w_mod_byte = RamRData_i;
        case (r_op)
            2'b00:   w_mod_byte = RamRData_i & ~w_mask;
            2'b01:   w_mod_byte = RamRData_i | w_mask;
            2'b10:   w_mod_byte = RamRData_i ^ w_mask;
            default: w_mod_byte = RamRData_i;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_capture  = 1'b0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_fsm_we   = 1'b0;
        w_fsm_addr = r_addr;
        w_wdata    = r_byte;
`ifdef FB_CLEAR_EN
        w_clr_start = 1'b0;
        w_clr_inc   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef FB_CLEAR_EN
                if (ClearStart_i) begin
                    w_next      = S_CLEAR;
                    w_clr_start = 1'b1;
                end else
`endif
                if (w_hs) begin
                    if (w_x_oor || w_y_oor || w_noop) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = w_x_oor || w_y_oor;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!VgaReq_i) w_next = S_MODIFY;
            end
            // Read data here is always ours: READ only advances on a non-VGA cycle.
            S_MODIFY: begin
                w_capture = 1'b1;
                w_next    = S_WRITE;
            end
            S_WRITE: begin
                if (!VgaReq_i) begin
                    w_fsm_we   = 1'b1;
                    w_done_nxt = 1'b1;
                    w_next     = S_IDLE;
                end
            end
`ifdef FB_CLEAR_EN
            S_CLEAR: begin
                w_fsm_addr = r_clr_cnt;
                w_wdata    = 8'h00;
                if (!VgaReq_i) begin
                    w_fsm_we = 1'b1;
                    if (r_clr_cnt == c_LAST) begin
                        w_done_nxt = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_clr_inc = 1'b1;
                    end
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign RamAddress_o = VgaReq_i ? VgaAddress_i : w_fsm_addr;
    assign RamWrite_o   = w_fsm_we;
    assign RamWData_o   = w_wdata;
    assign PixDone_o    = r_done;
    assign PixError_o   = r_err;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_bit      <= '0;
            r_op       <= '0;
            r_byte     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_vga_pend <= 1'b0;
            VgaData_o  <= '0;
        end else begin
            r_state    <= w_next;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_vga_pend <= VgaReq_i;
            if (r_vga_pend) VgaData_o <= RamRData_i;
            if (w_latch) begin
                r_addr <= w_pix_addr;
                r_bit  <= PixY_i[2:0];
                r_op   <= PixOp_i;
            end
            if (w_capture) r_byte <= w_mod_byte;
        end
    end

`ifdef FB_CLEAR_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)           r_clr_cnt <= '0;
        else if (w_clr_start) r_clr_cnt <= '0;
        else if (w_clr_inc)   r_clr_cnt <= r_clr_cnt + 1'b1;
    end
`endif

endmodule

`default_nettype wire
